// File: rtl/csi2tx_pixel_seq_gen.sv
// Sensor-side front end of the CSI-2 TX pixel-to-byte path: registers pixels, sequences them
// within the data-type group period and flags line-end, length and data-type conditions.
module csi2tx_pixel_seq_gen #(
  parameter int PXL_W  = 16,
  parameter int LCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sensor_pixel_vld,
  input  logic [PXL_W-1:0]  sensor_pixel_data,
  input  logic [5:0]        data_type,
  input  logic [LCNT_W-1:0] line_len_cfg,
  output logic [PXL_W-1:0]  pixel_data,
  output logic              pixel_data_vld,
  output logic [4:0]        pixel_cnt,
  output logic              sensor_pixel_vld_falling_edge,
  output logic              raw6_convrn_enable,
  output logic              raw7_convrn_enable,
  output logic              raw8_convrn_enable,
  output logic              raw10_convrn_enable,
  output logic              raw12_convrn_enable,
  output logic              raw14_convrn_enable,
  output logic [LCNT_W-1:0] line_pixel_cnt,
  output logic              line_len_err,
  output logic              dt_err
);

  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;

  // Returns {supported, period-1 mask, one-hot enable {raw14,raw12,raw10,raw8,raw7,raw6}}.
  function automatic logic [11:0] dt_decode(input logic [5:0] dt);
    logic [11:0] r;
    case (dt)
      6'h28:   r = {1'b1, 5'h0f, 6'b000001};
      6'h29:   r = {1'b1, 5'h1f, 6'b000010};
      6'h2a:   r = {1'b1, 5'h03, 6'b000100};
      6'h2b:   r = {1'b1, 5'h0f, 6'b001000};
      6'h2c:   r = {1'b1, 5'h07, 6'b010000};
      6'h2d:   r = {1'b1, 5'h0f, 6'b100000};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [LCNT_W-1:0] sat_inc(input logic [LCNT_W-1:0] v);
    return (v == LCNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [PXL_W-1:0]  data_p1;
  logic              vld_p1;
  logic              raw_vld_p1;
  logic [4:0]        cnt_p1;
  logic              fe_p1;
  logic              len_err_p1;
  logic              dt_err_p1;
  logic [5:0]        en_p1;
  logic [LCNT_W-1:0] lcnt_p1;
  logic [4:0]        mask_q;
  logic              line_ok_q;

  logic [11:0] dec;
  logic        dt_ok;
  logic        line_start;
  logic        line_fwd;
  logic        line_end;

  // Line start keys off the ungated strobe so an unsupported line is recognised only once.
  assign dec        = dt_decode(data_type);
  assign dt_ok      = dec[11];
  assign line_start = sensor_pixel_vld & ~raw_vld_p1;
  assign line_fwd   = line_start ? dt_ok : line_ok_q;
  assign line_end   = vld_p1 & ~sensor_pixel_vld;

  // Stage p1: registered pixel, sequence index and line status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1    <= '0;
      vld_p1     <= 1'b0;
      raw_vld_p1 <= 1'b0;
      cnt_p1     <= '0;
      fe_p1      <= 1'b0;
      len_err_p1 <= 1'b0;
      dt_err_p1  <= 1'b0;
      en_p1      <= '0;
      lcnt_p1    <= '0;
      mask_q     <= '0;
      line_ok_q  <= 1'b0;
    end else begin
      raw_vld_p1 <= sensor_pixel_vld;
      vld_p1     <= sensor_pixel_vld & line_fwd;
      if (sensor_pixel_vld) data_p1 <= sensor_pixel_data;
      fe_p1      <= line_end;
      len_err_p1 <= line_end && (line_len_cfg != '0) && (lcnt_p1 != line_len_cfg);
      dt_err_p1  <= line_start & ~dt_ok;
      if (line_start) begin
        line_ok_q <= dt_ok;
        mask_q    <= dec[10:6];
        en_p1     <= dec[5:0];
        lcnt_p1   <= {{(LCNT_W-1){1'b0}}, dt_ok};
        cnt_p1    <= '0;
      end else begin
        if (sensor_pixel_vld && line_ok_q) lcnt_p1 <= sat_inc(lcnt_p1);
        // During the line-end pulse this leaves the size of the final partial group.
        if (vld_p1) cnt_p1 <= (cnt_p1 + 5'd1) & mask_q;
        else        cnt_p1 <= '0;
      end
    end
  end

  assign pixel_data                    = data_p1;
  assign pixel_data_vld                = vld_p1;
  assign pixel_cnt                     = cnt_p1;
  assign sensor_pixel_vld_falling_edge = fe_p1;
  assign line_len_err                  = len_err_p1;
  assign dt_err                        = dt_err_p1;
  assign line_pixel_cnt                = lcnt_p1;
  assign raw6_convrn_enable            = en_p1[0];
  assign raw7_convrn_enable            = en_p1[1];
  assign raw8_convrn_enable            = en_p1[2];
  assign raw10_convrn_enable           = en_p1[3];
  assign raw12_convrn_enable           = en_p1[4];
  assign raw14_convrn_enable           = en_p1[5];

endmodule
